// File: rtl/park_pkg.sv
// Shared types and constants for the parking slot controller and its helpers.
package park_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TO_SLOT = 2'd1,
    TO_HOME = 2'd2
  } park_state_t;

  localparam logic OP_PARK     = 1'b0;
  localparam logic OP_RETRIEVE = 1'b1;
  localparam int   SLOT_NONE   = 0;

endpackage

// File: rtl/park_slot_find.sv
// Lowest-numbered free slot finder; slot numbers are 1-based, 0 when the garage is full.
module park_slot_find
  import park_pkg::*;
#(
  parameter  int NUM_SLOTS = 3,
  localparam int SLOT_W    = $clog2(NUM_SLOTS + 1)
) (
  input  logic [NUM_SLOTS-1:0] occupied,
  output logic [SLOT_W-1:0]    slot,
  output logic                 any_free
);

  // Scan from the top so the lowest free slot is the last one written.
  always_comb begin
    slot     = SLOT_W'(SLOT_NONE);
    any_free = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!occupied[i]) begin
        slot     = SLOT_W'(i + 1);
        any_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/park_slot_ctrl.sv
// Garage slot controller: accepts park/retrieve requests, times the carrier trip and
// commits slot occupancy when the carrier reaches the slot.
//
// state   | meaning
// IDLE    | carrier at home, request port open
// TO_SLOT | carrier travelling home -> slot; occupancy committed on arrival
// TO_HOME | carrier travelling slot -> home; done pulses on arrival
module park_slot_ctrl
  import park_pkg::*;
#(
  parameter  int NUM_SLOTS   = 3,
  parameter  int MOVE_CYCLES = 4,
  localparam int SLOT_W      = $clog2(NUM_SLOTS + 1),
  localparam int CNT_W       = $clog2(MOVE_CYCLES + 1)
) (
  input  logic                 clk_receive,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_op,
  input  logic [SLOT_W-1:0]    req_slot,
  output logic [NUM_SLOTS-1:0] occupied,
  output logic [SLOT_W-1:0]    free_count,
  output logic [SLOT_W-1:0]    moving_place,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MOVE_CYCLES - 1);

  park_state_t          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 op_q, op_d;
  logic [NUM_SLOTS-1:0] occ_d, target_mask;
  logic [SLOT_W-1:0]    free_d, move_d, free_slot, target;
  logic                 busy_d, done_d, err_d;
  logic                 any_free, slot_held, accept_ok, fire, tc;

  park_slot_find #(.NUM_SLOTS(NUM_SLOTS)) u_find (
    .occupied (occupied),
    .slot     (free_slot),
    .any_free (any_free)
  );

  assign req_ready   = (state_q == IDLE) & ~rst;
  assign fire        = req_valid & req_ready;
  assign tc          = (cnt_q == '0);
  assign target_mask = NUM_SLOTS'(1) << (moving_place - SLOT_W'(1));

  // Out-of-range retrieve slots (0 or > NUM_SLOTS) never match, so they read as empty.
  always_comb begin
    slot_held = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (req_slot == SLOT_W'(i + 1)) slot_held = occupied[i];
    end
    accept_ok = (req_op == OP_PARK) ? any_free : slot_held;
    target    = (req_op == OP_PARK) ? free_slot : req_slot;
  end

  always_ff @(posedge clk_receive) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      op_q         <= OP_PARK;
      occupied     <= '0;
      free_count   <= SLOT_W'(NUM_SLOTS);
      moving_place <= SLOT_W'(SLOT_NONE);
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      occupied     <= occ_d;
      free_count   <= free_d;
      moving_place <= move_d;
      busy         <= busy_d;
      done         <= done_d;
      err          <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fire && accept_ok) state_d = TO_SLOT;
      TO_SLOT: if (tc) state_d = TO_HOME;
      TO_HOME: if (tc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Travel timer counts down from MOVE_CYCLES-1; zero is the terminal count.
  always_comb begin
    cnt_d  = cnt_q;
    op_d   = op_q;
    occ_d  = occupied;
    free_d = free_count;
    move_d = moving_place;
    done_d = 1'b0;
    err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        move_d = SLOT_W'(SLOT_NONE);
        if (fire) begin
          if (accept_ok) begin
            move_d = target;
            op_d   = req_op;
            cnt_d  = CNT_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      TO_SLOT: begin
        if (tc) begin
          cnt_d = CNT_LOAD;
          if (op_q == OP_PARK) begin
            occ_d  = occupied | target_mask;
            free_d = free_count - SLOT_W'(1);
          end else begin
            occ_d  = occupied & ~target_mask;
            free_d = free_count + SLOT_W'(1);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      TO_HOME: begin
        if (tc) begin
          cnt_d  = '0;
          move_d = SLOT_W'(SLOT_NONE);
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: cnt_d = '0;
    endcase
    busy_d = (state_d != IDLE);
  end

endmodule
